matmul_feeder: RTL and testbench
================================

Name: matmul_feeder

Overview:
- Initiator that drives the dot-product accumulator (DIM-term accumulator with ena/data in, flag/acc out) to compute C = A × B for two DIM×DIM matrices held in synchronous-read memories.
- Generates A/B read addresses, multiplies operand pairs, and streams Q10.21 products with an ena strobe.
- Waits for the accumulator's flag, then raises a result write strobe with the C address so acc can be stored.
- Sits between the operand memories and the accumulator in the matrix datapath.

Parameters:
- DIM, 3, matrix dimension. Number of products per dot product. Legal values are 2 or more.
- NBIT_ADDR, $clog2(DIM*DIM), address width for the A, B and C memories (localparam).
- NBIT_IDX, $clog2(DIM)+1, width of the i/j/k counters (localparam).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to compute the full C; ignored while busy
- addr_a  output  NBIT_ADDR  A read address = i*DIM+k (row-major)
- addr_b  output  NBIT_ADDR  B read address = k*DIM+j (row-major)
- rd_en  output  1  read strobe for A and B; data returns the next cycle
- a_data  input  16  A element, signed Q4.11 [4:-11]
- b_data  input  16  B element, signed Q4.11 [4:-11]
- data  output  32  product to the accumulator, signed [10:-21]
- ena  output  1  product valid, to the accumulator
- flag  input  1  accumulator dot-product-complete flag
- res_addr  output  NBIT_ADDR  C address = i*DIM+j
- res_we  output  1  C write strobe; acc is valid while high
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse after the last C element is written

Behaviour:
- Reset (async, rst=0): state IDLE; i, j, k = 0. All outputs 0: addr_a, addr_b, rd_en, data, ena, res_addr, res_we, busy, done.
- Reset mid-operation aborts immediately. No resume; a new start is required.
- FSM states: IDLE, RUN, WAIT, DONE.
- IDLE:
  - start=1 → RUN, busy=1, i=j=k=0.
- RUN: one cycle per k.
  - Drive rd_en=1 and the addresses for the current (i,j,k).
  - k = DIM-1 → WAIT, k reset to 0.
- Pipeline:
  - Stage 1: rd_en registered, data valid one cycle later.
  - Stage 2: full product p = a_data*b_data (32-bit [9:-22]). Registered as data = {p[31], p[31:1]}: sign-extended, LSB truncated toward -inf.
  - ena is rd_en delayed 2 cycles; latency address→ena = 2 cycles.
  - data holds its last value when ena=0.
- Guard: ena must be 0 in any cycle where flag=1, because the accumulator clears on that edge and ignores input. The schedule guarantees this; an assertion checks it.
- WAIT:
  - Hold rd_en=0 and wait for flag.
  - On flag=1: res_we=1 (combinational from state and flag), res_addr = i*DIM+j (registered, stable through WAIT).
  - Then advance j; on j wrap (j = DIM-1 → 0) advance i.
  - i=j=DIM-1 → DONE, otherwise → RUN.
  - flag arrives 3 cycles after the last RUN cycle, so each C element costs DIM+3 cycles.
- DONE: done=1 for one cycle, busy=0, → IDLE.
- start while busy: ignored, no effect on state or counters.
- flag in IDLE, RUN or DONE: ignored (res_we stays 0).
- Wrap-around: i and j never exceed DIM-1. NBIT_IDX counters compare exactly against DIM-1.
- Total run: DIM*DIM*(DIM+3) cycles from the first RUN cycle to the last res_we, then 1 cycle to done.

Test Plan:
1. Reset, then pulse start with DIM=3, A=I and B[k][j]=k*3+j (all Q4.11) → res_we fires 9 times; acc (accumulator model) at res_addr n equals B[n]; done pulses at cycle 55 after start; busy high throughout.
2. Single product check with a_data=0x0800 (1.0) and b_data=0xF800 (-1.0) → data=0xFFE00000 (-1.0 in Q10.21) with ena exactly 2 cycles after rd_en.
3. Truncation: a_data=0x0001, b_data=0x0001 (p=1 LSB of Q9.22) → data=0x00000000. a_data=0xFFFF, b_data=0x0001 → data=0xFFFFFFFF (floor).
4. Pulse start again on cycle 10 of a run → counters, addresses and total cycle count unchanged; exactly one done.
5. Drive rst low in RUN at (i,j,k)=(1,2,1) → all outputs 0 asynchronously. After release, a new start restarts at addr_a=0, addr_b=0.
6. Inject a spurious flag pulse during RUN → no res_we, no state change. Throughout all tests, assert ena & flag is never 1 in the same cycle.

Source files
------------

// File: rtl/matmul_feeder_if.sv
// Memory-side and accumulator-side signals of the matrix feeder, grouped as one bundle.
// The feeder takes the master view; memories, accumulator and controller take the slave view.
interface matmul_feeder_if #(
    parameter int DIM = 3
);
    localparam int NBIT_ADDR = $clog2(DIM*DIM);

    logic                 start;
    logic [NBIT_ADDR-1:0] addr_a;
    logic [NBIT_ADDR-1:0] addr_b;
    logic                 rd_en;
    logic [15:0]          a_data;
    logic [15:0]          b_data;
    logic [31:0]          data;
    logic                 ena;
    logic                 flag;
    logic [NBIT_ADDR-1:0] res_addr;
    logic                 res_we;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, a_data, b_data, flag,
        output addr_a, addr_b, rd_en, data, ena, res_addr, res_we, busy, done
    );

    modport slave (
        output start, a_data, b_data, flag,
        input  addr_a, addr_b, rd_en, data, ena, res_addr, res_we, busy, done
    );
endinterface

// File: rtl/matmul_feeder.sv
// Walks (i,j,k) over two DIMxDIM operand memories, streams Q10.21 products into a
// dot-product accumulator and strobes each finished C element for write-back.
module matmul_feeder_chk (
    input logic clk,
    input logic rst,
    input logic ena,
    input logic flag
);
    // The accumulator clears on a flag edge and drops any product presented alongside it.
    ena_flag_exclusive: assert property (@(posedge clk) disable iff (!rst) !(ena && flag));
endmodule

module matmul_feeder #(
    parameter int DIM = 3
) (
    input logic             clk,
    input logic             rst,
    matmul_feeder_if.master bus
);
    localparam int NBIT_ADDR = $clog2(DIM*DIM);
    localparam int NBIT_IDX  = $clog2(DIM) + 1;

    localparam logic [NBIT_IDX-1:0]  IDX_ZERO  = {NBIT_IDX{1'b0}};
    localparam logic [NBIT_IDX-1:0]  IDX_ONE   = {{(NBIT_IDX-1){1'b0}}, 1'b1};
    localparam logic [NBIT_IDX-1:0]  IDX_LAST  = NBIT_IDX'(DIM - 32'sd1);
    localparam logic [NBIT_ADDR-1:0] ADDR_ZERO = {NBIT_ADDR{1'b0}};
    localparam logic [NBIT_ADDR-1:0] DIM_A     = NBIT_ADDR'(DIM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [NBIT_IDX-1:0]  i_r, j_r, k_r;
    logic [NBIT_IDX-1:0]  i_s, j_s, k_s;

    logic                 rd_en_s, busy_s, done_s, res_we_s;
    logic [NBIT_ADDR-1:0] addr_a_s, addr_b_s, res_addr_s;
    logic signed [31:0]   prod_s;

    logic                 rd_en_r, rd_en_d1_r, ena_r, busy_r, done_r;
    logic [NBIT_ADDR-1:0] addr_a_r, addr_b_r, res_addr_r;
    logic [31:0]          data_r;

    function automatic logic [NBIT_ADDR-1:0] flat_addr(
        input logic [NBIT_IDX-1:0] row,
        input logic [NBIT_IDX-1:0] col
    );
        return NBIT_ADDR'(row) * DIM_A + NBIT_ADDR'(col);
    endfunction

    // State and loop counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            i_r     <= IDX_ZERO;
            j_r     <= IDX_ZERO;
            k_r     <= IDX_ZERO;
        end else begin
            state_r <= state_s;
            i_r     <= i_s;
            j_r     <= j_s;
            k_r     <= k_s;
        end
    end

    // Next state and counters; start is only honoured from IDLE.
    always_comb begin
        state_s = state_r;
        i_s     = i_r;
        j_s     = j_r;
        k_s     = k_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = RUN;
                    i_s     = IDX_ZERO;
                    j_s     = IDX_ZERO;
                    k_s     = IDX_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (k_r == IDX_LAST) begin
                    state_s = WAIT;
                    k_s     = IDX_ZERO;
                end else begin
                    k_s     = k_r + IDX_ONE;
                end
            end
            WAIT: begin
                if (bus.flag) begin
                    if (j_r == IDX_LAST) begin
                        j_s = IDX_ZERO;
                        i_s = (i_r == IDX_LAST) ? IDX_ZERO : i_r + IDX_ONE;
                    end else begin
                        j_s = j_r + IDX_ONE;
                    end
                    state_s = ((i_r == IDX_LAST) && (j_r == IDX_LAST)) ? DONE : RUN;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                i_s     = IDX_ZERO;
                j_s     = IDX_ZERO;
                k_s     = IDX_ZERO;
            end
        endcase
    end

    // Output decode: registered outputs are precomputed from the next state and counters.
    always_comb begin
        rd_en_s    = (state_s == RUN);
        busy_s     = (state_s == RUN) || (state_s == WAIT);
        done_s     = (state_s == DONE);
        addr_a_s   = flat_addr(i_s, k_s);
        addr_b_s   = flat_addr(k_s, j_s);
        res_addr_s = flat_addr(i_s, j_s);
        res_we_s   = (state_r == WAIT) && bus.flag;
        prod_s     = 32'($signed(bus.a_data)) * 32'($signed(bus.b_data));
    end

    // Output registers and the read/multiply pipeline (ena trails rd_en by two cycles).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_r    <= 1'b0;
            rd_en_d1_r <= 1'b0;
            ena_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            addr_a_r   <= ADDR_ZERO;
            addr_b_r   <= ADDR_ZERO;
            res_addr_r <= ADDR_ZERO;
            data_r     <= 32'd0;
        end else begin
            rd_en_r    <= rd_en_s;
            rd_en_d1_r <= rd_en_r;
            ena_r      <= rd_en_d1_r;
            busy_r     <= busy_s;
            done_r     <= done_s;
            addr_a_r   <= addr_a_s;
            addr_b_r   <= addr_b_s;
            res_addr_r <= res_addr_s;
            // Q9.22 -> Q10.21 by arithmetic shift, i.e. floor toward -inf.
            if (rd_en_d1_r) begin
                data_r <= prod_s >>> 1'b1;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign bus.rd_en    = rd_en_r;
    assign bus.addr_a   = addr_a_r;
    assign bus.addr_b   = addr_b_r;
    assign bus.data     = data_r;
    assign bus.ena      = ena_r;
    assign bus.res_addr = res_addr_r;
    assign bus.res_we   = res_we_s;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

    matmul_feeder_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena_r),
        .flag (bus.flag)
    );
endmodule

// File: tb/tb_matmul_feeder.sv
// Randomised scoreboard bench for matmul_feeder with memory and accumulator models.
module tb_matmul_feeder;
    localparam int DIM        = 3;
    localparam int NA         = $clog2(DIM*DIM);
    localparam int RUN_CYCLES = DIM*DIM*(DIM+3) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matmul_feeder_if #(.DIM(DIM)) bus ();
    matmul_feeder #(.DIM(DIM)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] mem_a [DIM*DIM];
    logic [15:0] mem_b [DIM*DIM];

    // Synchronous-read operand memories.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.a_data <= mem_a[bus.addr_a];
            bus.b_data <= mem_b[bus.addr_b];
        end
    end

    // Accumulator model: sums DIM products, raises flag, clears on the flag cycle.
    logic [31:0] acc;
    int          acc_cnt;
    logic        acc_flag;
    logic        spur_flag = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= 32'd0; acc_cnt <= 0; acc_flag <= 1'b0;
        end else if (acc_flag) begin
            acc <= 32'd0; acc_cnt <= 0; acc_flag <= 1'b0;
        end else if (bus.ena) begin
            acc <= acc + bus.data;
            if (acc_cnt == DIM-1) begin acc_flag <= 1'b1; acc_cnt <= 0; end
            else acc_cnt <= acc_cnt + 1;
        end
    end
    assign bus.flag = acc_flag | spur_flag;

    int          exp_aa_q[$], exp_ab_q[$], exp_ra_q[$], rd_cyc_q[$];
    logic [31:0] exp_prod_q[$], exp_rv_q[$];
    logic [31:0] first_prod [3];
    logic [31:0] last_data = 32'd0;
    int n_prod = 0, res_idx = 0, done_cnt = 0, done_cyc = 0, busy_gap = 0;
    int run_lo = 0, run_hi = 0;
    bit dir_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=unexpected-event required=none", name);
    endtask

    // Reference product: exact a*b in Q9.22, halved with floor to Q10.21.
    function automatic logic [31:0] q_prod(input logic [15:0] a, input logic [15:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        if (p >= 0) return 32'(p / 2);
        else        return 32'(-((1 - p) / 2));
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({bus.addr_a, bus.addr_b, bus.rd_en, bus.data, bus.ena,
                    bus.res_addr, bus.res_we, bus.busy, bus.done});
    endfunction

    task automatic plan_run();
        logic [31:0] csum, pr;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                csum = 32'd0;
                for (int k = 0; k < DIM; k++) begin
                    exp_aa_q.push_back(i*DIM + k);
                    exp_ab_q.push_back(k*DIM + j);
                    pr = q_prod(mem_a[i*DIM + k], mem_b[k*DIM + j]);
                    exp_prod_q.push_back(pr);
                    csum = csum + pr;
                end
                exp_ra_q.push_back(i*DIM + j);
                exp_rv_q.push_back(csum);
            end
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an address, product or result.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.rd_en) begin
                if (exp_aa_q.size() == 0) fail_now("rd_en_extra");
                else check("rd_addr", 64'({bus.addr_a, bus.addr_b}),
                           64'({NA'(exp_aa_q.pop_front()), NA'(exp_ab_q.pop_front())}));
                rd_cyc_q.push_back(cyc);
            end
            if (bus.ena) begin
                if (exp_prod_q.size() == 0) fail_now("ena_extra");
                else check("product", 64'(bus.data), 64'(exp_prod_q.pop_front()));
                if (rd_cyc_q.size() != 0) check("ena_latency", 64'(cyc - rd_cyc_q.pop_front()), 64'd2);
                if (n_prod < 3) first_prod[n_prod] = bus.data;
                n_prod++;
                last_data = bus.data;
            end
            if (bus.flag) check("ena_flag_guard", 64'(bus.ena), 64'd0);
            if (bus.res_we) begin
                check("data_hold", 64'(bus.data), 64'(last_data));
                if (exp_ra_q.size() == 0) fail_now("res_we_extra");
                else begin
                    check("res_addr", 64'(bus.res_addr), 64'(exp_ra_q.pop_front()));
                    check("c_value", 64'(acc), 64'(exp_rv_q.pop_front()));
                end
                if (dir_mode) check("c_identity", 64'(acc), 64'(32'(res_idx) << 21));
                res_idx++;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_not_busy", 64'(bus.busy), 64'd0);
            end
            if (cyc >= run_lo && cyc < run_hi && !bus.busy) busy_gap++;
        end
    end

    task automatic run_mat(input int extra_start, input bit spur);
        int s, d0;
        bit spur_done;
        plan_run();
        d0 = done_cnt; res_idx = 0; n_prod = 0; busy_gap = 0; spur_done = 1'b0;
        @(posedge clk); #2;
        s = cyc; run_lo = s + 1; run_hi = s + RUN_CYCLES;
        bus.start = 1'b1;
        for (int t = 1; t <= RUN_CYCLES + 8; t++) begin
            @(posedge clk); #2;
            bus.start = (t == extra_start);
            spur_flag = 1'b0;
            if (t == 1) check("first_addr", 64'({bus.rd_en, bus.addr_a, bus.addr_b}), 64'(1) << (2*NA));
            if (spur && !spur_done && t > DIM+3 && bus.rd_en && !bus.ena) begin
                spur_flag = 1'b1;
                spur_done = 1'b1;
                #1 check("spur_res_we", 64'(bus.res_we), 64'd0);
            end
        end
        if (spur) check("spur_injected", 64'(spur_done), 64'd1);
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("done_cycle", 64'(done_cyc - s), 64'(RUN_CYCLES));
        check("busy_high", 64'(busy_gap), 64'd0);
        check("sb_drained", 64'(exp_aa_q.size() + exp_prod_q.size() + exp_ra_q.size()), 64'd0);
        run_lo = 0; run_hi = 0;
    endtask

    task automatic reset_abort();
        bit hit;
        hit = 1'b0;
        plan_run();
        @(posedge clk); #2;
        bus.start = 1'b1;
        for (int t = 1; t <= RUN_CYCLES && !hit; t++) begin
            @(posedge clk); #2;
            bus.start = 1'b0;
            if (bus.rd_en && bus.addr_a == NA'(DIM + 1) && bus.addr_b == NA'(DIM + 2)) hit = 1'b1;
        end
        check("abort_point_found", 64'(hit), 64'd1);
        rst = 1'b0;
        #1 check("abort_outs_zero", all_outs(), 64'd0);
        exp_aa_q.delete(); exp_ab_q.delete(); exp_prod_q.delete();
        exp_ra_q.delete(); exp_rv_q.delete(); rd_cyc_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic fill_random();
        for (int n = 0; n < DIM*DIM; n++) begin
            mem_a[n] = 16'($urandom);
            mem_b[n] = 16'($urandom);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        #1 rst = 1'b0;
        #1 check("reset_outs", all_outs(), 64'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Identity A times counting B: every C element must equal the matching B element.
        for (int n = 0; n < DIM*DIM; n++) begin
            mem_a[n] = (n / DIM == n % DIM) ? 16'h0800 : 16'h0000;
            mem_b[n] = 16'(n << 11);
        end
        dir_mode = 1'b1;
        run_mat(-1, 1'b0);
        dir_mode = 1'b0;

        // First dot product exercises -1.0 product and both truncation corners.
        fill_random();
        mem_a[0] = 16'h0800; mem_b[0]     = 16'hF800;
        mem_a[1] = 16'h0001; mem_b[DIM]   = 16'h0001;
        mem_a[2] = 16'hFFFF; mem_b[2*DIM] = 16'h0001;
        run_mat(-1, 1'b0);
        check("prod_minus_one", 64'(first_prod[0]), 64'hFFE00000);
        check("prod_trunc_zero", 64'(first_prod[1]), 64'h00000000);
        check("prod_trunc_floor", 64'(first_prod[2]), 64'hFFFFFFFF);

        fill_random();
        run_mat(10, 1'b0);
        fill_random();
        run_mat(-1, 1'b1);

        fill_random();
        reset_abort();
        run_mat(-1, 1'b0);

        for (int r = 0; r < 2; r++) begin
            fill_random();
            run_mat(-1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
